// File: rtl/uart_time_sender_pkg.sv
// Shared constants, state encoding and time snapshot layout for the time-line sender.
// No logic, no latency, no flow control.
package uart_time_sender_pkg;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam int LINE_LEN_MSEC   = 13;
    localparam int LINE_LEN_NOMSEC = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] msec;
    } time_t;

endpackage

// File: rtl/uart_time_sender_if.sv
// Request/time inputs and byte handshake of the time-line sender; master is the sender side.
// Wires only: no latency; backpressure is carried by i_tx_busy/i_tx_done.
interface uart_time_sender_if;
    logic       i_send;
    logic [4:0] i_hour;
    logic [5:0] i_min;
    logic [5:0] i_sec;
    logic [6:0] i_msec;
    logic       i_tx_busy;
    logic       i_tx_done;
    logic       o_start;
    logic [7:0] o_tx_data;
    logic       o_busy;
    logic       o_done;

    modport master (
        input  i_send, i_hour, i_min, i_sec, i_msec, i_tx_busy, i_tx_done,
        output o_start, o_tx_data, o_busy, o_done
    );

    modport slave (
        output i_send, i_hour, i_min, i_sec, i_msec, i_tx_busy, i_tx_done,
        input  o_start, o_tx_data, o_busy, o_done
    );
endinterface

// File: rtl/uart_time_sender_bin2ascii2.sv
// Binary 0..127 to two ASCII decimal digits, saturating at 99.
// Combinational, zero latency, no flow control.
module uart_time_sender_bin2ascii2
    import uart_time_sender_pkg::*;
(
    input  logic [6:0] bin,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [6:0] rem;
    logic [3:0] cnt;

    // Nine conditional subtract stages cover 0..99 without a divider.
    always_comb begin
        rem = (bin > 7'd99) ? 7'd99 : bin;
        cnt = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (rem >= 7'd10) begin
                rem = rem - 7'd10;
                cnt = cnt + 4'd1;
            end
        end
        tens = ASC_ZERO + {4'd0, cnt};
        ones = ASC_ZERO + {1'b0, rem};
    end

endmodule

// File: rtl/uart_time_sender.sv
// Snapshots the time on request and streams "HH:MM:SS[.cc]\r\n" to uart_tx. First start 2 clocks after accept.
// Backpressure: a byte is only issued while i_tx_busy=0; the next waits for i_tx_done.
module uart_time_sender
    import uart_time_sender_pkg::*;
#(
    parameter bit SEND_MSEC = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    uart_time_sender_if.master  bus
);

    localparam int         LEN      = SEND_MSEC ? LINE_LEN_MSEC : LINE_LEN_NOMSEC;
    localparam logic [3:0] LAST_IDX = 4'(LEN - 1);

    state_t     state, state_n;
    logic [3:0] idx, idx_n;
    time_t      snap, snap_n;
    logic       start_q, start_n;
    logic [7:0] data_q, data_n;
    logic       busy_q, busy_n;
    logic       done_q, done_n;

    logic [7:0] h1, h0, m1, m0, s1, s0, c1, c0;
    logic [7:0] cur_byte;

    uart_time_sender_bin2ascii2 u_hour (.bin({2'b00, snap.hour}), .tens(h1), .ones(h0));
    uart_time_sender_bin2ascii2 u_min  (.bin({1'b0, snap.min}),   .tens(m1), .ones(m0));
    uart_time_sender_bin2ascii2 u_sec  (.bin({1'b0, snap.sec}),   .tens(s1), .ones(s0));
    uart_time_sender_bin2ascii2 u_msec (.bin(snap.msec),          .tens(c1), .ones(c0));

    // Positions 8 and 9 differ depending on whether the centisecond field is sent.
    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            4'd0:    cur_byte = h1;
            4'd1:    cur_byte = h0;
            4'd2:    cur_byte = ASC_COLON;
            4'd3:    cur_byte = m1;
            4'd4:    cur_byte = m0;
            4'd5:    cur_byte = ASC_COLON;
            4'd6:    cur_byte = s1;
            4'd7:    cur_byte = s0;
            4'd8:    cur_byte = SEND_MSEC ? ASC_DOT : ASC_CR;
            4'd9:    cur_byte = SEND_MSEC ? c1 : ASC_LF;
            4'd10:   cur_byte = c0;
            4'd11:   cur_byte = ASC_CR;
            4'd12:   cur_byte = ASC_LF;
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        snap_n  = snap;
        start_n = 1'b0;
        data_n  = data_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_send) begin
                    snap_n  = '{hour: bus.i_hour, min: bus.i_min, sec: bus.i_sec, msec: bus.i_msec};
                    idx_n   = 4'd0;
                    busy_n  = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.i_tx_busy) begin
                    start_n = 1'b1;
                    data_n  = cur_byte;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.i_tx_done) begin
                    if (idx == LAST_IDX) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        idx_n   = idx + 4'd1;
                        state_n = ST_ISSUE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= 4'd0;
            snap    <= '0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            snap    <= snap_n;
            start_q <= start_n;
            data_q  <= data_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.o_start   = start_q;
    assign bus.o_tx_data = data_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;

endmodule

// File: tb/tb_uart_time_sender.sv
// Drives one sender with and one without centiseconds against a simple transmitter model,
// comparing every emitted line with a decimal-arithmetic reference.
module tb_uart_time_sender;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       send_v [2];
    logic       hold   [2];
    logic       mbusy  [2];
    logic       mdone  [2];
    int         cnt    [2];
    int         tx_cyc;
    logic [4:0] hour_v;
    logic [5:0] min_v, sec_v;
    logic [6:0] msec_v;

    uart_time_sender_if if0 ();
    uart_time_sender_if if1 ();

    assign if0.i_send    = send_v[0];
    assign if0.i_hour    = hour_v;
    assign if0.i_min     = min_v;
    assign if0.i_sec     = sec_v;
    assign if0.i_msec    = msec_v;
    assign if0.i_tx_busy = mbusy[0] | hold[0];
    assign if0.i_tx_done = mdone[0];
    assign if1.i_send    = send_v[1];
    assign if1.i_hour    = hour_v;
    assign if1.i_min     = min_v;
    assign if1.i_sec     = sec_v;
    assign if1.i_msec    = msec_v;
    assign if1.i_tx_busy = mbusy[1] | hold[1];
    assign if1.i_tx_done = mdone[1];

    uart_time_sender #(.SEND_MSEC(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    uart_time_sender #(.SEND_MSEC(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    logic       start_s [2];
    logic [7:0] data_s  [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    assign start_s[0] = if0.o_start;
    assign start_s[1] = if1.o_start;
    assign data_s[0]  = if0.o_tx_data;
    assign data_s[1]  = if1.o_tx_data;
    assign busy_s[0]  = if0.o_busy;
    assign busy_s[1]  = if1.o_busy;
    assign done_s[0]  = if0.o_done;
    assign done_s[1]  = if1.o_done;

    logic [7:0] got0[$];
    logic [7:0] got1[$];
    logic [7:0] want[$];
    int         n_start    [2];
    int         n_done     [2];
    logic       prev_start [2];
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Transmitter model plus byte collector, acting on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    cnt[k]   = 0;
                    mbusy[k] = 1'b0;
                    mdone[k] = 1'b0;
                end else begin
                    mdone[k] = 1'b0;
                    if (cnt[k] > 0) begin
                        cnt[k]--;
                        if (cnt[k] == 0) begin
                            mbusy[k] = 1'b0;
                            mdone[k] = 1'b1;
                        end
                    end else if (start_s[k] === 1'b1) begin
                        mbusy[k] = 1'b1;
                        cnt[k]   = tx_cyc;
                    end
                end
                if (start_s[k] === 1'b1) begin
                    chk("start_width", {31'd0, prev_start[k]}, 32'd0);
                    chk("busy_at_start", {31'd0, busy_s[k]}, 32'd1);
                    if (k == 0) got0.push_back(data_s[k]);
                    else        got1.push_back(data_s[k]);
                    n_start[k]++;
                end
                if (done_s[k] === 1'b1) n_done[k]++;
                prev_start[k] = start_s[k];
            end
        end
    end

    function automatic logic [7:0] asc(input int v, input bit hi);
        int x;
        x = (v > 99) ? 99 : v;
        return hi ? 8'(48 + x / 10) : 8'(48 + x % 10);
    endfunction

    task automatic build_exp(input int h, input int m, input int s, input int c, input bit ms);
        want.delete();
        want.push_back(asc(h, 1)); want.push_back(asc(h, 0)); want.push_back(8'h3A);
        want.push_back(asc(m, 1)); want.push_back(asc(m, 0)); want.push_back(8'h3A);
        want.push_back(asc(s, 1)); want.push_back(asc(s, 0));
        if (ms) begin
            want.push_back(8'h2E); want.push_back(asc(c, 1)); want.push_back(asc(c, 0));
        end
        want.push_back(8'h0D); want.push_back(8'h0A);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c);
        hour_v = 5'(h); min_v = 6'(m); sec_v = 6'(s); msec_v = 7'(c);
    endtask

    task automatic fire(input int k);
        send_v[k] = 1'b1;
        tick(1);
        send_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input string tag);
        int t = 0;
        while (done_s[k] !== 1'b1 && t < 4000) begin
            tick(1);
            t++;
        end
        chk({tag, "_done_seen"}, {31'd0, done_s[k]}, 32'd1);
    endtask

    task automatic check_line(input int k, input string tag);
        logic [7:0] g[$];
        if (k == 0) begin g = got0; got0.delete(); end
        else        begin g = got1; got1.delete(); end
        chk({tag, "_len"}, 32'(g.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++)
            if (i < g.size()) chk($sformatf("%s_byte%0d", tag, i), {24'd0, g[i]}, {24'd0, want[i]});
    endtask

    initial begin
        int s;
        int t;
        int k;
        int h, m, sc, c;
        for (int i = 0; i < 2; i++) begin
            send_v[i] = 1'b0; hold[i] = 1'b0; mbusy[i] = 1'b0; mdone[i] = 1'b0;
            cnt[i] = 0; n_start[i] = 0; n_done[i] = 0; prev_start[i] = 1'b0;
        end
        tx_cyc = 3;
        set_time(0, 0, 0, 0);
        rst = 1'b1;
        tick(3);
        for (int i = 0; i < 2; i++) begin
            chk("rst_start", {31'd0, start_s[i]}, 32'd0);
            chk("rst_data",  {24'd0, data_s[i]},  32'd0);
            chk("rst_busy",  {31'd0, busy_s[i]},  32'd0);
            chk("rst_done",  {31'd0, done_s[i]},  32'd0);
        end
        rst = 1'b0;
        tick(1);

        // Full line with centiseconds, including first-start latency.
        set_time(12, 34, 56, 78);
        build_exp(12, 34, 56, 78, 1'b1);
        fire(0);
        chk("accept_busy",  {31'd0, busy_s[0]},  32'd1);
        chk("accept_quiet", {31'd0, start_s[0]}, 32'd0);
        tick(1);
        chk("first_start", {31'd0, start_s[0]}, 32'd1);
        chk("first_byte",  {24'd0, data_s[0]},  32'h31);
        wait_done(0, "msec");
        chk("msec_busy_clear", {31'd0, busy_s[0]}, 32'd0);
        check_line(0, "msec");
        tick(2);
        chk("msec_done_count", 32'(n_done[0]), 32'd1);

        // Line without centiseconds.
        set_time(3, 7, 9, 42);
        build_exp(3, 7, 9, 42, 1'b0);
        s = n_start[1];
        fire(1);
        wait_done(1, "nomsec");
        check_line(1, "nomsec");
        chk("nomsec_starts", 32'(n_start[1] - s), 32'd10);

        // Snapshot isolation and centisecond saturation.
        set_time(12, 34, 56, 120);
        build_exp(12, 34, 56, 120, 1'b1);
        fire(0);
        set_time(23, 59, 59, 99);
        wait_done(0, "snap");
        check_line(0, "snap");

        // Transmitter held busy while the first byte is pending.
        hold[0] = 1'b1;
        s = n_start[0];
        set_time(8, 5, 0, 1);
        build_exp(8, 5, 0, 1, 1'b1);
        fire(0);
        tick(50);
        chk("hold_no_start", 32'(n_start[0] - s), 32'd0);
        chk("hold_busy",     {31'd0, busy_s[0]}, 32'd1);
        hold[0] = 1'b0;
        wait_done(0, "hold");
        check_line(0, "hold");

        // Request during WAIT is dropped; request in the done cycle is taken.
        set_time(10, 20, 30, 40);
        build_exp(10, 20, 30, 40, 1'b1);
        fire(0);
        tick(2);
        fire(0);
        wait_done(0, "wait_ignore");
        check_line(0, "wait_ignore");
        set_time(21, 0, 5, 99);
        build_exp(21, 0, 5, 99, 1'b1);
        fire(0);
        chk("b2b_accept", {31'd0, busy_s[0]}, 32'd1);
        wait_done(0, "b2b");
        check_line(0, "b2b");
        s = n_start[0];
        tick(20);
        chk("b2b_no_extra", 32'(n_start[0] - s), 32'd0);
        chk("b2b_idle",     {31'd0, busy_s[0]}, 32'd0);

        // Reset in the middle of a line, then a clean restart.
        set_time(15, 45, 30, 12);
        s = n_start[0];
        fire(0);
        t = 0;
        while (n_start[0] - s < 5 && t < 2000) begin tick(1); t++; end
        chk("mid_reached", {31'd0, (n_start[0] - s >= 5)}, 32'd1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_start", {31'd0, start_s[0]}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy_s[0]},  32'd0);
        chk("mid_rst_data",  {24'd0, data_s[0]},  32'd0);
        rst = 1'b0;
        got0.delete();
        tick(2);
        set_time(14, 2, 3, 4);
        build_exp(14, 2, 3, 4, 1'b1);
        fire(0);
        tick(1);
        chk("restart_start", {31'd0, start_s[0]}, 32'd1);
        chk("restart_byte",  {24'd0, data_s[0]},  32'h31);
        wait_done(0, "restart");
        check_line(0, "restart");

        // Random times, including out-of-range fields, with random transmitter speed.
        for (int r = 0; r < 8; r++) begin
            k      = r % 2;
            tx_cyc = int'($urandom_range(1, 6));
            h      = int'($urandom_range(0, 31));
            m      = int'($urandom_range(0, 63));
            sc     = int'($urandom_range(0, 63));
            c      = int'($urandom_range(0, 127));
            set_time(h, m, sc, c);
            build_exp(h, m, sc, c, (k == 0));
            fire(k);
            wait_done(k, $sformatf("rand%0d", r));
            check_line(k, $sformatf("rand%0d", r));
            tick(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_time_sender.md
Name: uart_time_sender

Overview:
- Upstream producer for the UART transmitter. On request, snapshots the clock's current time and serialises it as an ASCII line, "HH:MM:SS.cc\r\n" or "HH:MM:SS\r\n".
- Feeds the transmitter one byte at a time through its start/din/busy/done handshake.
- Sits between the digital-clock time counters and the uart_tx instance in the UART subsystem.

Parameters:
- SEND_MSEC, 1, 1 sends the ".cc" centisecond field (13-byte line); 0 omits it (10-byte line).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- i_send  in  1  request to send one time line; level or pulse; sampled only in IDLE
- i_hour  in  5  hour, 0..23
- i_min  in  6  minute, 0..59
- i_sec  in  6  second, 0..59
- i_msec  in  7  centiseconds, 0..99
- i_tx_busy  in  1  transmitter busy (uart_tx o_tx_busy)
- i_tx_done  in  1  one-cycle byte-complete pulse (uart_tx o_tx_done)
- o_start  out  1  one-cycle start pulse to the transmitter
- o_tx_data  out  8  byte to the transmitter; valid while o_start=1
- o_busy  out  1  line transmission in progress
- o_done  out  1  one-cycle pulse when the last byte completes

Behaviour:
- All outputs are registered. Reset values: o_start=0, o_tx_data=8'h00, o_busy=0, o_done=0, state=IDLE, byte index=0, snapshot=0.
- States: IDLE, ISSUE, WAIT.
- IDLE, i_send=1 at edge E:
  - Capture hour/min/sec/msec into the snapshot registers.
  - Set idx=0, o_busy=1, go to ISSUE.
  - Later input changes do not affect the line in flight.
- ISSUE, i_tx_busy=0:
  - Next edge sets o_start=1 and o_tx_data=byte[idx], then goes to WAIT.
  - While i_tx_busy=1, stay in ISSUE and emit no start.
  - The first o_start is high in cycle E+2.
- WAIT:
  - o_start returns to 0 after exactly one cycle.
  - o_tx_data holds its value until the next start.
  - On i_tx_done=1: if idx==LEN-1, go to IDLE with o_busy=0 and o_done=1 for one cycle. Otherwise idx++ and go to ISSUE.
- LEN = 13 when SEND_MSEC=1, else 10.
- Byte order, SEND_MSEC=1: H1 H0 ':' M1 M0 ':' S1 S0 '.' C1 C0 CR LF. With SEND_MSEC=0 the '.', C1 and C0 bytes are dropped.
- Digit conversion:
  - tens = v/10, ones = v%10, implemented as a compare/subtract chain (no divider).
  - ASCII byte = 8'h30 + digit. Leading zeros are always sent (7 -> "07").
- Saturation: any field value >99 (possible only on i_msec) is sent as "99". Out-of-range values 24..31 / 60..63 are sent as-is (two digits) and not flagged.
- Inputs ignored:
  - i_send outside IDLE; it is not queued.
  - i_tx_done outside WAIT.
- o_done cycle: the state is already IDLE, so i_send=1 in that cycle is accepted (back-to-back lines).
- rst mid-line: immediate return to IDLE with all outputs at reset values; no partial-byte recovery. The transmitter shares the same rst.
- idx is 4 bits and never exceeds LEN-1.

Decomposition:
- Shared package:
  - ASCII constants: ASC_ZERO=8'h30, ASC_COLON=8'h3A, ASC_DOT=8'h2E, ASC_CR=8'h0D, ASC_LF=8'h0A.
  - State encodings.
  - Line lengths: 13 and 10.
- One sub-module, bin2ascii2: 7-bit binary in, saturating at 99 -> two 8-bit ASCII digits out; combinational. Instantiated four times on the snapshot registers.

Test Plan:
- Line with msec: SEND_MSEC=1, time 12:34:56.78, i_send pulse, uart_tx behavioural model -> bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A in order; one o_done; o_busy high throughout.
- Line without msec: SEND_MSEC=0, time 03:07:09 -> 30 33 3A 30 37 3A 30 39 0D 0A; exactly 10 o_start pulses.
- Snapshot and saturation: inputs change to 23:59:59 right after acceptance -> the original line is sent unchanged. i_msec=120 -> C1 C0 = 39 39.
- Handshake: i_tx_busy held high for 50 cycles in ISSUE -> no o_start until it drops. Every o_start is exactly one cycle wide. i_send during WAIT is ignored. i_send in the o_done cycle starts a new line.
- Reset: rst asserted during byte 5 -> next cycle o_start=0, o_busy=0, o_tx_data=00. A fresh i_send restarts from byte 0 (31 for hour 1x).
